// File: rtl/coin_collector_fsm.sv
// Vending-machine front end: tallies coin pulses, then hands money and price to the
// change-dispenser FSM through a start/done handshake guarded by a timeout.
module coin_collector_fsm #(
  parameter logic [6:0]  MAX_MONEY      = 7'd99,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_Q,
  input  logic       coin_D,
  input  logic       coin_N,
  input  logic       coin_P,
  input  logic [6:0] price,
  input  logic       select,
  input  logic       cancel,
  input  logic       done,
  output logic [6:0] money,
  output logic [6:0] price_out,
  output logic       start,
  output logic       coin_reject,
  output logic       vended,
  output logic       refunded,
  output logic       error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  // Price above any legal tally makes the dispenser return everything.
  localparam logic [6:0] REFUND_PRICE = 7'd127;

  logic [2:0]  state_q, state_d;
  logic [6:0]  money_q, money_d;
  logic [6:0]  price_q, price_d;
  logic [15:0] timer_q, timer_d;
  logic        cancel_flag_q, cancel_flag_d;
  logic        start_q, start_d;
  logic        reject_q, reject_d;
  logic        vended_q, vended_d;
  logic        refunded_q, refunded_d;
  logic        error_q, error_d;

  logic [7:0]  coin_value;
  logic [7:0]  coin_sum;
  logic        coin_any;
  logic        coin_fits;
  logic [15:0] timer_inc;
  logic        timed_out;

  assign coin_value = (coin_Q ? 8'd25 : 8'd0) + (coin_D ? 8'd10 : 8'd0)
                    + (coin_N ? 8'd5 : 8'd0) + (coin_P ? 8'd1 : 8'd0);
  assign coin_sum   = {1'b0, money_q} + coin_value;
  assign coin_any   = (coin_value != 8'd0);
  assign coin_fits  = (coin_sum <= {1'b0, MAX_MONEY});
  assign timer_inc  = timer_q + 16'd1;
  assign timed_out  = (timer_inc >= TIMEOUT_CYCLES);

  always_comb begin
    state_d       = state_q;
    money_d       = money_q;
    price_d       = price_q;
    timer_d       = timer_q;
    cancel_flag_d = cancel_flag_q;
    start_d       = start_q;
    reject_d      = 1'b0;
    vended_d      = 1'b0;
    refunded_d    = 1'b0;
    error_d       = error_q;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if ((state_q == S_COLLECT) && cancel) begin
          price_d       = REFUND_PRICE;
          cancel_flag_d = 1'b1;
          state_d       = S_START;
          start_d       = 1'b1;
          timer_d       = 16'd0;
          reject_d      = coin_any;
        end else if ((state_q == S_COLLECT) && select && (money_q >= price)) begin
          price_d       = price;
          cancel_flag_d = 1'b0;
          state_d       = S_START;
          start_d       = 1'b1;
          timer_d       = 16'd0;
          reject_d      = coin_any;
        end else if (coin_any) begin
          if (coin_fits) begin
            money_d = coin_sum[6:0];
            state_d = S_COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_START: begin
        reject_d = coin_any;
        if (!done) begin
          state_d = S_WAIT;
          start_d = 1'b0;
          timer_d = 16'd0;
        end else if (timed_out) begin
          state_d = S_ERROR;
          start_d = 1'b0;
          error_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT: begin
        reject_d = coin_any;
        if (done) begin
          money_d    = 7'd0;
          price_d    = 7'd0;
          vended_d   = ~cancel_flag_q;
          refunded_d = cancel_flag_q;
          state_d    = S_IDLE;
        end else if (timed_out) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_ERROR: begin
        reject_d = coin_any;
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      money_q       <= 7'd0;
      price_q       <= 7'd0;
      timer_q       <= 16'd0;
      cancel_flag_q <= 1'b0;
      start_q       <= 1'b0;
      reject_q      <= 1'b0;
      vended_q      <= 1'b0;
      refunded_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      money_q       <= money_d;
      price_q       <= price_d;
      timer_q       <= timer_d;
      cancel_flag_q <= cancel_flag_d;
      start_q       <= start_d;
      reject_q      <= reject_d;
      vended_q      <= vended_d;
      refunded_q    <= refunded_d;
      error_q       <= error_d;
    end
  end

  assign money       = money_q;
  assign price_out   = price_q;
  assign start       = start_q;
  assign coin_reject = reject_q;
  assign vended      = vended_q;
  assign refunded    = refunded_q;
  assign error       = error_q;

endmodule

// File: tb/tb_coin_collector_fsm.sv
// Directed bench for coin_collector_fsm: coin tally, purchase, refund, overflow and timeout.
module tb_coin_collector_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_Q = 1'b0, coin_D = 1'b0, coin_N = 1'b0, coin_P = 1'b0;
  logic [6:0] price = 7'd0;
  logic       select = 1'b0, cancel = 1'b0, done = 1'b1;
  logic [6:0] money, price_out;
  logic       start, coin_reject, vended, refunded, error;

  int checks = 0;
  int errors = 0;

  coin_collector_fsm dut (
    .clk(clk), .reset(reset),
    .coin_Q(coin_Q), .coin_D(coin_D), .coin_N(coin_N), .coin_P(coin_P),
    .price(price), .select(select), .cancel(cancel), .done(done),
    .money(money), .price_out(price_out), .start(start), .coin_reject(coin_reject),
    .vended(vended), .refunded(refunded), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic q, input logic d, input logic n, input logic p);
    coin_Q = q; coin_D = d; coin_N = n; coin_P = p;
    tick();
    coin_Q = 1'b0; coin_D = 1'b0; coin_N = 1'b0; coin_P = 1'b0;
  endtask

  // Dispenser drops done for one cycle, then reports finished.
  task automatic handshake();
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    price = 7'd10; select = 1'b1; tick(); select = 1'b0;
    done = 1'b0; tick();
    reset = 1'b0; tick(); tick();
    checks++; if (money !== 7'd0) begin errors++;
      $display("FAIL rst_money got %0d want 0", money); end
    checks++; if (price_out !== 7'd0) begin errors++;
      $display("FAIL rst_price_out got %0d want 0", price_out); end
    checks++; if ({start, coin_reject, vended, refunded, error} !== 5'b0) begin errors++;
      $display("FAIL rst_flags got %b want 00000",
               {start, coin_reject, vended, refunded, error}); end
    checks++; if (dut.state_q !== 3'd0) begin errors++;
      $display("FAIL rst_state got %0d want 0", dut.state_q); end
    reset = 1'b1; done = 1'b1;
    select = 1'b1; price = 7'd0; tick(); select = 1'b0;
    checks++; if (start !== 1'b0) begin errors++;
      $display("FAIL idle_select_ignored start got %b want 0", start); end
  endtask

  task automatic test_purchase();
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (money !== 7'd25) begin errors++;
      $display("FAIL buy_money_q1 got %0d want 25", money); end
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    coin(1'b0, 1'b1, 1'b0, 1'b0);
    coin(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (money !== 7'd61) begin errors++;
      $display("FAIL buy_money got %0d want 61", money); end
    price = 7'd50; select = 1'b1; tick(); select = 1'b0;
    checks++; if (start !== 1'b1 || price_out !== 7'd50) begin errors++;
      $display("FAIL buy_start got start=%b price_out=%0d want 1/50", start, price_out); end
    tick(); tick();
    checks++; if (start !== 1'b1) begin errors++;
      $display("FAIL buy_start_held got %b want 1", start); end
    done = 1'b0; tick();
    checks++; if (start !== 1'b0 || vended !== 1'b0) begin errors++;
      $display("FAIL buy_wait got start=%b vended=%b want 0/0", start, vended); end
    done = 1'b1; tick();
    checks++; if (vended !== 1'b1 || refunded !== 1'b0) begin errors++;
      $display("FAIL buy_vended got vended=%b refunded=%b want 1/0", vended, refunded); end
    checks++; if (money !== 7'd0 || price_out !== 7'd0) begin errors++;
      $display("FAIL buy_clear got money=%0d price_out=%0d want 0/0", money, price_out); end
    tick();
    checks++; if (vended !== 1'b0) begin errors++;
      $display("FAIL buy_vended_pulse got %b want 0", vended); end
  endtask

  task automatic test_overflow();
    coin(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (money !== 7'd41) begin errors++;
      $display("FAIL ovf_group got %0d want 41", money); end
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (money !== 7'd91 || coin_reject !== 1'b0) begin errors++;
      $display("FAIL ovf_91 got money=%0d reject=%b want 91/0", money, coin_reject); end
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (money !== 7'd91 || coin_reject !== 1'b1) begin errors++;
      $display("FAIL ovf_reject got money=%0d reject=%b want 91/1", money, coin_reject); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++;
      $display("FAIL ovf_reject_pulse got %b want 0", coin_reject); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    handshake();
    checks++; if (refunded !== 1'b1 || money !== 7'd0) begin errors++;
      $display("FAIL ovf_refund got refunded=%b money=%0d want 1/0", refunded, money); end
  endtask

  task automatic test_cancel();
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    coin(1'b0, 1'b0, 1'b1, 1'b0);
    price = 7'd45; select = 1'b1; tick(); select = 1'b0;
    checks++; if (start !== 1'b0 || money !== 7'd30) begin errors++;
      $display("FAIL low_select got start=%b money=%0d want 0/30", start, money); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++; if (start !== 1'b1 || price_out !== 7'd127) begin errors++;
      $display("FAIL cancel_start got start=%b price_out=%0d want 1/127", start, price_out); end
    handshake();
    checks++; if (refunded !== 1'b1 || vended !== 1'b0) begin errors++;
      $display("FAIL cancel_refund got refunded=%b vended=%b want 1/0", refunded, vended); end
    checks++; if (money !== 7'd0) begin errors++;
      $display("FAIL cancel_clear got money=%0d want 0", money); end
  endtask

  task automatic test_timeout();
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    price = 7'd20; select = 1'b1; tick(); select = 1'b0;
    for (int i = 0; i < 250; i++) tick();
    checks++; if (error !== 1'b0 || start !== 1'b1) begin errors++;
      $display("FAIL to_early got error=%b start=%b want 0/1", error, start); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (error !== 1'b0) begin errors++;
      $display("FAIL to_254 got error=%b want 0", error); end
    tick();
    checks++; if (error !== 1'b1 || start !== 1'b0) begin errors++;
      $display("FAIL to_error got error=%b start=%b want 1/0", error, start); end
    coin(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || money !== 7'd25 || price_out !== 7'd20) begin
      errors++;
      $display("FAIL to_coin got reject=%b money=%0d price_out=%0d want 1/25/20",
               coin_reject, money, price_out); end
    tick(); tick();
    checks++; if (error !== 1'b1) begin errors++;
      $display("FAIL to_held got %b want 1", error); end
    reset = 1'b0; tick(); reset = 1'b1;
    checks++; if (error !== 1'b0 || money !== 7'd0) begin errors++;
      $display("FAIL to_reset got error=%b money=%0d want 0/0", error, money); end
  endtask

  task automatic test_back_to_back();
    coin(1'b1, 1'b0, 1'b0, 1'b0);
    coin(1'b0, 1'b1, 1'b0, 1'b0);
    coin(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (money !== 7'd40) begin errors++;
      $display("FAIL both_money got %0d want 40", money); end
    price = 7'd25; select = 1'b1; cancel = 1'b1; coin_P = 1'b1;
    tick();
    select = 1'b0; cancel = 1'b0; coin_P = 1'b0;
    checks++; if (price_out !== 7'd127 || start !== 1'b1) begin errors++;
      $display("FAIL both_cancel_wins got price_out=%0d start=%b want 127/1",
               price_out, start); end
    checks++; if (coin_reject !== 1'b1 || money !== 7'd40) begin errors++;
      $display("FAIL both_coin got reject=%b money=%0d want 1/40", coin_reject, money); end
    handshake();
    checks++; if (refunded !== 1'b1 || vended !== 1'b0) begin errors++;
      $display("FAIL both_refund got refunded=%b vended=%b want 1/0", refunded, vended); end
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_overflow();
    test_cancel();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
